// File: rtl/cache_pkg.sv
// Shared definitions for the cache miss/refill path.
// Contents: address field widths, beat geometry and the refill FSM state type.
package cache_pkg;

    localparam int ADDR_W   = 64;
    localparam int TAG_W    = 52;   // addr[63:12]
    localparam int INDEX_W  = 6;    // addr[11:6]
    localparam int OFFSET_W = 6;    // addr[5:0]
    localparam int BEAT_W   = 64;
    localparam int BEATS    = 64 * 8 / BEAT_W;
    localparam int CNT_W    = $clog2(BEATS);

    // Mask that clears the byte-offset bits to form a block-aligned address.
    localparam logic [ADDR_W-1:0] OFFSET_MASK = ADDR_W'((64'd1 << OFFSET_W) - 64'd1);

    typedef enum logic [2:0] {
        IDLE,
        INVAL,
        REQ,
        FILL,
        COMMIT
    } refill_state_e;

endpackage

// File: rtl/cache_refill_if.sv
// Bundle of every handshake/bus signal around the refill block.
//   miss_*     : miss request from set lookup (valid/ready)
//   mem_req_*  : burst read request to memory (valid/ready)
//   mem_resp_* : returning beats, no backpressure
//   ram_*      : data RAM write port
//   tag_*      : tag/valid array write port
//   refill_*   : completion / error pulses
// Modports: master = the refill block, slave = its surroundings.
interface cache_refill_if;
    import cache_pkg::*;

    logic                miss_valid;
    logic                miss_ready;
    logic [ADDR_W-1:0]   miss_addr;

    logic                mem_req_valid;
    logic                mem_req_ready;
    logic [ADDR_W-1:0]   mem_req_addr;

    logic                mem_resp_valid;
    logic [BEAT_W-1:0]   mem_resp_data;
    logic                mem_resp_last;

    logic                ram_wen;
    logic [INDEX_W-1:0]  ram_index;
    logic [OFFSET_W-1:0] ram_offset;
    logic [BEAT_W-1:0]   ram_wdata;

    logic                tag_we;
    logic [INDEX_W-1:0]  tag_index;
    logic [TAG_W-1:0]    tag_value;
    logic                tag_valid;

    logic                refill_done;
    logic                refill_err;

    modport master (
        input  miss_valid, miss_addr, mem_req_ready,
               mem_resp_valid, mem_resp_data, mem_resp_last,
        output miss_ready, mem_req_valid, mem_req_addr,
               ram_wen, ram_index, ram_offset, ram_wdata,
               tag_we, tag_index, tag_value, tag_valid,
               refill_done, refill_err
    );

    modport slave (
        output miss_valid, miss_addr, mem_req_ready,
               mem_resp_valid, mem_resp_data, mem_resp_last,
        input  miss_ready, mem_req_valid, mem_req_addr,
               ram_wen, ram_index, ram_offset, ram_wdata,
               tag_we, tag_index, tag_value, tag_valid,
               refill_done, refill_err
    );

endinterface

// File: rtl/cache_refill.sv
// Cache miss refill engine.
// Accepts one miss at a time, invalidates the target block, issues a single
// block-aligned burst read, writes each returned beat into the data RAM and
// finally commits tag+valid. A burst whose last flag disagrees with the beat
// count is reported with refill_err and the block stays invalid.
// Ports:
//   clk : clock
//   rst : asynchronous reset, active-low
//   bus : cache_refill_if.master (miss, memory request/response, RAM, tag, status)
module cache_refill
    import cache_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    cache_refill_if.master bus
);

    refill_state_e      state;
    refill_state_e      state_nxt;
    logic [CNT_W-1:0]   beat_cnt;
    logic [ADDR_W-1:0]  addr_q;

    logic               beat;
    logic               final_beat;

    assign beat       = (state == FILL) && bus.mem_resp_valid;
    assign final_beat = (beat_cnt == CNT_W'(BEATS - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            beat_cnt <= '0;
            addr_q   <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && bus.miss_valid) begin
                addr_q <= bus.miss_addr;
            end
            if (state == REQ && bus.mem_req_ready) begin
                beat_cnt <= '0;
            end else if (beat) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt         = state;
        bus.miss_ready    = 1'b0;
        bus.mem_req_valid = 1'b0;
        bus.ram_wen       = 1'b0;
        bus.tag_we        = 1'b0;
        bus.tag_valid     = 1'b0;
        bus.refill_done   = 1'b0;
        bus.refill_err    = 1'b0;
        case (state)
            IDLE: begin
                bus.miss_ready = 1'b1;
                if (bus.miss_valid) begin
                    state_nxt = INVAL;
                end
            end
            INVAL: begin
                // Clear valid before any data lands so a half-filled block never hits.
                bus.tag_we = 1'b1;
                state_nxt  = REQ;
            end
            REQ: begin
                bus.mem_req_valid = 1'b1;
                if (bus.mem_req_ready) begin
                    state_nxt = FILL;
                end
            end
            FILL: begin
                if (beat) begin
                    // The beat is written even when it exposes a length error.
                    bus.ram_wen = 1'b1;
                    if (bus.mem_resp_last && final_beat) begin
                        state_nxt = COMMIT;
                    end else if (bus.mem_resp_last || final_beat) begin
                        bus.refill_err = 1'b1;
                        state_nxt      = IDLE;
                    end
                end
            end
            COMMIT: begin
                bus.tag_we      = 1'b1;
                bus.tag_valid   = 1'b1;
                bus.refill_done = 1'b1;
                state_nxt       = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Address fields come straight from the latch, so they hold still while
    // the request waits for mem_req_ready.
    assign bus.mem_req_addr = addr_q & ~OFFSET_MASK;
    assign bus.ram_index    = addr_q[OFFSET_W +: INDEX_W];
    assign bus.ram_offset   = {beat_cnt, 3'b000};
    assign bus.ram_wdata    = bus.ram_wen ? bus.mem_resp_data : '0;
    assign bus.tag_index    = addr_q[OFFSET_W +: INDEX_W];
    assign bus.tag_value    = addr_q[ADDR_W-1 -: TAG_W];

endmodule

// File: tb/tb_cache_refill.sv
// Self-checking bench for cache_refill: directed scenarios plus randomized
// refills, with expected behaviour derived from address arithmetic and the
// beat schedule the bench itself drives.
module tb_cache_refill;
    import cache_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    cache_refill_if bus();

    cache_refill dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet_outputs(input string tag);
        chk({tag, "_miss_ready"},  bus.miss_ready, 1);
        chk({tag, "_req_valid"},   bus.mem_req_valid, 0);
        chk({tag, "_req_addr"},    bus.mem_req_addr, 0);
        chk({tag, "_ram_wen"},     bus.ram_wen, 0);
        chk({tag, "_ram_offset"},  bus.ram_offset, 0);
        chk({tag, "_ram_wdata"},   bus.ram_wdata, 0);
        chk({tag, "_tag_we"},      bus.tag_we, 0);
        chk({tag, "_tag_index"},   bus.tag_index, 0);
        chk({tag, "_done"},        bus.refill_done, 0);
        chk({tag, "_err"},         bus.refill_err, 0);
    endtask

    // One refill transaction.
    //   rdly     : cycles mem_req_ready is withheld while a request is pending
    //   gaps     : idle response cycle after every beat
    //   last_at  : beat carrying last (7 = legal, <7 early, 8 = never)
    //   rst_beat : beat index at which reset is asserted (-1 = none)
    //   hold     : keep miss_valid high after acceptance
    task automatic do_refill(input logic [63:0] a, input int rdly, input bit gaps,
                             input int last_at, input int rst_beat, input bit hold);
        logic [63:0]        d [BEATS];
        logic [INDEX_W-1:0] idx;
        logic [TAG_W-1:0]   tag;
        int cyc, phase, waited, k, nw, ntag, nreq, ndone, nerr;
        int end_cyc, done_cyc, err_cyc, rst_cyc, n_exp, last_idx, step;
        bit hs, gap_now, fin, in_rst, rst_seen, overlap, busy_ready, ok_exp, err_exp;

        for (int i = 0; i < BEATS; i++) d[i] = {$urandom(), $urandom()};
        idx      = a[11:6];
        tag      = a[63:12];
        last_idx = (last_at < 7) ? last_at : 7;
        step     = gaps ? 2 : 1;
        ok_exp   = (rst_beat < 0) && (last_at == 7);
        err_exp  = (rst_beat < 0) && (last_at != 7);
        n_exp    = (rst_beat >= 0) ? rst_beat : last_idx + 1;
        phase = 0; waited = 0; k = 0; nw = 0; ntag = 0; nreq = 0; ndone = 0; nerr = 0;
        end_cyc = 0; done_cyc = -1; err_cyc = -1; rst_cyc = -1;
        gap_now = 0; fin = 0; in_rst = 0; rst_seen = 0; overlap = 0; busy_ready = 0;

        @(posedge clk); #1;
        bus.miss_valid = 1'b1;
        bus.miss_addr  = a;
        @(negedge clk);
        chk("miss_ready_idle", bus.miss_ready, 1);
        @(posedge clk); #1;
        cyc = 1;
        if (!hold) begin
            bus.miss_valid = 1'b0;
            bus.miss_addr  = {$urandom(), $urandom()};
        end

        while (!(fin && cyc > end_cyc + 3) && cyc < 300) begin
            hs = 0;
            bus.mem_req_ready  = 1'b0;
            bus.mem_resp_valid = 1'($urandom_range(0, 1));
            bus.mem_resp_last  = 1'($urandom_range(0, 1));
            bus.mem_resp_data  = {$urandom(), $urandom()};
            if (phase == 0) begin
                if (bus.mem_req_valid) begin
                    if (waited >= rdly) begin
                        bus.mem_req_ready = 1'b1;
                        hs = 1;
                    end else begin
                        waited++;
                    end
                end
            end else if (phase == 1) begin
                if (gap_now) begin
                    bus.mem_resp_valid = 1'b0;
                    gap_now = 0;
                end else begin
                    bus.mem_resp_valid = 1'b1;
                    bus.mem_resp_data  = d[k];
                    bus.mem_resp_last  = (k == last_at);
                    if (k == rst_beat) begin
                        bus.mem_resp_last = 1'b0;
                        rst_n    = 1'b0;
                        in_rst   = 1;
                        rst_seen = 1;
                        rst_cyc  = cyc;
                        phase    = 2;
                        #1;
                        chk_quiet_outputs("async_rst");
                    end else if (k == last_at || k == BEATS - 1) begin
                        phase = 2;
                    end
                    k++;
                    gap_now = gaps;
                end
            end else begin
                if (in_rst && cyc == rst_cyc + 1) begin
                    rst_n  = 1'b1;
                    in_rst = 0;
                end
            end

            @(negedge clk);
            if (bus.ram_wen && bus.tag_we) overlap = 1;
            if (!fin) begin
                if (!rst_seen && bus.miss_ready) busy_ready = 1;
                if (bus.mem_req_valid) begin
                    nreq++;
                    chk("req_addr", bus.mem_req_addr, {a[63:6], 6'b000000});
                end
                if (bus.ram_wen) begin
                    if (nw < BEATS) begin
                        chk("ram_index", bus.ram_index, idx);
                        chk("ram_offset", bus.ram_offset, nw * 8);
                        chk("ram_wdata", bus.ram_wdata, d[nw]);
                    end else begin
                        chk("ram_extra_write", nw, BEATS - 1);
                    end
                    nw++;
                end
                if (bus.tag_we) begin
                    if (ntag == 0) begin
                        chk("inval_valid", bus.tag_valid, 0);
                        chk("inval_index", bus.tag_index, idx);
                        chk("inval_cycle", cyc, 1);
                    end else begin
                        chk("commit_valid", bus.tag_valid, 1);
                        chk("commit_index", bus.tag_index, idx);
                        chk("commit_tag", bus.tag_value, tag);
                    end
                    ntag++;
                end
                if (bus.refill_done) begin ndone++; done_cyc = cyc; end
                if (bus.refill_err)  begin nerr++;  err_cyc  = cyc; end
                if (ndone > 0 || nerr > 0 || rst_seen) begin
                    fin     = 1;
                    end_cyc = cyc;
                end
            end else begin
                if (cyc == end_cyc + 1) chk("miss_ready_after", bus.miss_ready, 1);
                if (hold && cyc == end_cyc + 2)
                    chk("rearm_inval", bus.tag_we && !bus.tag_valid, 1);
            end

            @(posedge clk); #1;
            cyc++;
            if (hs) phase = 1;
        end

        chk("finished_in_budget", fin, 1);
        chk("done_count", ndone, ok_exp);
        chk("err_count", nerr, err_exp);
        chk("write_count", nw, n_exp);
        chk("tag_writes", ntag, ok_exp ? 2 : 1);
        chk("req_cycles", nreq, rdly + 1);
        chk("ram_tag_overlap", overlap, 0);
        chk("ready_while_busy", busy_ready, 0);
        if (ok_exp)  chk("done_cycle", done_cyc, 3 + rdly + 7 * step + 1);
        if (err_exp) chk("err_cycle", err_cyc, 3 + rdly + last_idx * step);
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk_quiet_outputs("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [63:0] ra;
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        bus.miss_valid     = 1'b0;
        bus.miss_addr      = '0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = '0;
        bus.mem_resp_last  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_quiet_outputs("init_reset");
        rst_n = 1'b1;

        do_refill(64'h0000_0000_0001_2345, 0, 0, 7, -1, 0);
        do_refill(64'h0000_0000_0001_2345, 5, 0, 7, -1, 0);
        do_refill({$urandom(), $urandom()}, 0, 1, 7, -1, 0);
        do_refill({$urandom(), $urandom()}, 0, 0, 4, -1, 0);
        do_refill({$urandom(), $urandom()}, 1, 0, 8, -1, 0);
        do_refill({$urandom(), $urandom()}, 0, 0, 7, 3, 0);
        do_refill({$urandom(), $urandom()}, 0, 0, 7, -1, 1);
        bus.miss_valid = 1'b0;
        apply_reset();

        for (int t = 0; t < 8; t++) begin
            ra = {$urandom(), $urandom()};
            do_refill(ra, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 2) == 0) ? $urandom_range(0, 8) : 7, -1, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
